// File: rtl/alu_result_queue_if.sv
// Handshake bundle between the ALU (EX) and writeback (WB) around the result queue.
// Latency: none. Wires only.
// Backpressure: in_ready/out_ready carry the stall information in each direction.
//
// Signals: in_* is the ALU-side entry with its valid/ready pair.
//          out_* is the head entry offered to writeback with its valid/ready pair.
// Modports: slave  = the queue (consumes in_*, produces out_*)
//           master = the surrounding pipeline / bench (produces in_*, consumes out_*)
interface alu_result_queue_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_zero;
  logic [REG_W-1:0]  in_rd;
  logic              in_wr_en;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic [REG_W-1:0]  out_rd;
  logic              out_wr_en;

  modport slave (
    input  in_valid, in_result, in_zero, in_rd, in_wr_en, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_rd, out_wr_en
  );

  modport master (
    output in_valid, in_result, in_zero, in_rd, in_wr_en, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_rd, out_wr_en
  );
endinterface

// File: rtl/alu_result_queue.sv
// First-word-fall-through queue of ALU results (result, zero flag, rd, wr_en) between EX and WB.
// Latency: a push into an empty queue is visible on out_* one cycle after the push edge. There is no bypass.
// Backpressure: in_ready = !full from registered count. A pop never frees a slot for a same-cycle push.
//
// Ports: clk, rst_n (async active-low), flush (sync discard of all entries, highest priority)
//        q     : alu_result_queue_if.slave carrying the in_* / out_* handshakes
//        count : occupancy; full / empty decoded from count
//        drop_cnt (only with ALU_RESULT_QUEUE_STATS_EN): saturating count of upstream stall cycles
// Optional feature macro: ALU_RESULT_QUEUE_STATS_EN
module alu_result_queue #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  alu_result_queue_if.slave            q,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
`ifdef ALU_RESULT_QUEUE_STATS_EN
  ,
  output logic [7:0]                   drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic [REG_W-1:0]  rd;
    logic              wr_en;
  } entry_t;

  // Occupancy class, decoded from count each cycle.
  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];

  occ_e   occ;
  logic   push;
  logic   pop;
  entry_t in_entry;
  entry_t head;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign q.in_ready = ~full;
  assign q.out_valid = ~empty;

  assign push = q.in_valid & ~full;
  assign pop  = ~empty & q.out_ready;

  assign in_entry = '{result: q.in_result, zero: q.in_zero, rd: q.in_rd, wr_en: q.in_wr_en};
  assign head     = mem_q[rd_ptr_q];

  // Outputs read as zero while empty so WB never sees stale storage.
  always_comb begin
    q.out_result = '0;
    q.out_zero   = 1'b0;
    q.out_rd     = '0;
    q.out_wr_en  = 1'b0;
    if (!empty) begin
      q.out_result = head.result;
      q.out_zero   = head.zero;
      q.out_rd     = head.rd;
      q.out_wr_en  = head.wr_en;
    end
  end

  always_comb begin
    if (count_q == '0) begin
      occ = OCC_EMPTY;
    end else if (count_q == CNT_W'(DEPTH)) begin
      occ = OCC_FULL;
    end else begin
      occ = OCC_PARTIAL;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    unique case (occ)
      OCC_EMPTY: begin
        if (push) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          count_d  = count_q + CNT_W'(1);
        end
      end
      OCC_PARTIAL: begin
        if (push) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
          count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
          count_d = count_q - CNT_W'(1);
        end
      end
      OCC_FULL: begin
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          count_d  = count_q - CNT_W'(1);
        end
      end
      default: begin
        count_d = '0;
      end
    endcase

    if (push && !flush) begin
      mem_d[wr_ptr_q] = in_entry;
    end

    // Flush wins over any same-cycle push or pop.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: empty queues mask it at the output.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef ALU_RESULT_QUEUE_STATS_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (q.in_valid && full && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
    if (flush) begin
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
module tb_alu_result_queue;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [2:0] count;
  logic       full;
  logic       empty;
`ifdef ALU_RESULT_QUEUE_STATS_EN
  logic [7:0] drop_cnt;
`endif

  int total;
  int bad;

  alu_result_queue_if #(.DATA_W(16), .REG_W(3)) qif ();

  alu_result_queue #(.DATA_W(16), .REG_W(3), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .q        (qif),
    .count    (count),
    .full     (full),
    .empty    (empty)
`ifdef ALU_RESULT_QUEUE_STATS_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus and the state expected after its rising edge.
  typedef struct {
    logic        iv;
    logic [15:0] val;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [15:0] e_val;
    int          e_cnt;
  } vec_t;

  vec_t vt[$];

  // Side fields derived from the result value so each vector only names the value.
  function automatic logic [2:0] rd_of(input logic [15:0] v);
    logic [2:0] lo;
    lo = v[2:0];
    return lo ^ 3'd3;
  endfunction

  function automatic logic we_of(input logic [15:0] v);
    return ~v[0];
  endfunction

  function automatic logic z_of(input logic [15:0] v);
    return (v == 16'h0000);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] val, input logic ordy, input logic fl);
    qif.in_valid  = iv;
    qif.in_result = val;
    qif.in_zero   = z_of(val);
    qif.in_rd     = rd_of(val);
    qif.in_wr_en  = we_of(val);
    qif.out_ready = ordy;
    flush         = fl;
  endtask

  task automatic check_state(input string tag, input logic e_ov, input logic [15:0] e_val, input int e_cnt);
    check({tag, "_out_valid"},  32'(qif.out_valid),  32'(e_ov));
    check({tag, "_out_result"}, 32'(qif.out_result), e_ov ? 32'(e_val) : 32'd0);
    check({tag, "_out_zero"},   32'(qif.out_zero),   e_ov ? 32'(z_of(e_val)) : 32'd0);
    check({tag, "_out_rd"},     32'(qif.out_rd),     e_ov ? 32'(rd_of(e_val)) : 32'd0);
    check({tag, "_out_wr_en"},  32'(qif.out_wr_en),  e_ov ? 32'(we_of(e_val)) : 32'd0);
    check({tag, "_count"},      32'(count),          32'(e_cnt));
    check({tag, "_full"},       32'(full),           32'(e_cnt == 4));
    check({tag, "_empty"},      32'(empty),          32'(e_cnt == 0));
    check({tag, "_in_ready"},   32'(qif.in_ready),   32'(e_cnt != 4));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);

    //        iv  val       ordy  fl    e_ov  e_val     cnt
    vt.push_back('{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1}); // first push, rd=3 zero=1
    vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 0});
    vt.push_back('{1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0001, 1});
    vt.push_back('{1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0001, 2});
    vt.push_back('{1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 16'h0001, 3});
    vt.push_back('{1'b1, 16'h0004, 1'b0, 1'b0, 1'b1, 16'h0001, 4}); // full
    vt.push_back('{1'b1, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0001, 4}); // refused
    vt.push_back('{1'b1, 16'h0005, 1'b1, 1'b0, 1'b1, 16'h0002, 3}); // pop frees no same-cycle slot
    vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0003, 2});
    vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0004, 1});
    vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 0});
    vt.push_back('{1'b1, 16'h0008, 1'b0, 1'b0, 1'b1, 16'h0008, 1}); // pointers at 1, wraps ahead
    vt.push_back('{1'b1, 16'h0009, 1'b0, 1'b0, 1'b1, 16'h0008, 2});
    vt.push_back('{1'b1, 16'h0010, 1'b1, 1'b0, 1'b1, 16'h0009, 2}); // push+pop, count holds
    vt.push_back('{1'b1, 16'h0011, 1'b1, 1'b0, 1'b1, 16'h0010, 2});
    vt.push_back('{1'b1, 16'h0012, 1'b1, 1'b0, 1'b1, 16'h0011, 2});
    vt.push_back('{1'b1, 16'h0013, 1'b1, 1'b0, 1'b1, 16'h0012, 2});
    vt.push_back('{1'b1, 16'h0014, 1'b1, 1'b0, 1'b1, 16'h0013, 2});
    vt.push_back('{1'b1, 16'h0015, 1'b1, 1'b0, 1'b1, 16'h0014, 2});
    vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0015, 1});
    vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 0});
    vt.push_back('{1'b1, 16'h0020, 1'b0, 1'b0, 1'b1, 16'h0020, 1});
    vt.push_back('{1'b1, 16'h0021, 1'b0, 1'b0, 1'b1, 16'h0020, 2});
    vt.push_back('{1'b1, 16'h0022, 1'b0, 1'b0, 1'b1, 16'h0020, 3});
    vt.push_back('{1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0, 16'h0000, 0}); // flush beats push and pop
    vt.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 0}); // BEEF never surfaces
    vt.push_back('{1'b1, 16'h0030, 1'b0, 1'b0, 1'b1, 16'h0030, 1});

    // Reset state while rst_n is held low.
    #12;
    check_state("reset", 1'b0, 16'h0000, 0);
`ifdef ALU_RESULT_QUEUE_STATS_EN
    check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].iv, vt[i].val, vt[i].ordy, vt[i].fl);
      @(negedge clk);
      check_state($sformatf("v%0d", i), vt[i].e_ov, vt[i].e_val, vt[i].e_cnt);
    end

    // Asynchronous reset between edges with one entry queued.
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 1'b0, 16'h0000, 0);
    @(negedge clk);
    check_state("async_rst_held", 1'b0, 16'h0000, 0);
    rst_n = 1'b1;

`ifdef ALU_RESULT_QUEUE_STATS_EN
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(16'h0040 + i), 1'b0, 1'b0);
      @(negedge clk);
    end
    check("stats_fill_drop_cnt", 32'(drop_cnt), 32'd0);
    check("stats_fill_full", 32'(full), 32'd1);
    drive(1'b1, 16'h0050, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("stats_drop_5", 32'(drop_cnt), 32'd5);
    for (int i = 0; i < 295; i++) @(negedge clk);
    check("stats_drop_sat", 32'(drop_cnt), 32'd255);
    drive(1'b1, 16'h0050, 1'b0, 1'b1);
    @(negedge clk);
    check("stats_flush_drop_cnt", 32'(drop_cnt), 32'd0);
    check("stats_flush_count", 32'(count), 32'd0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    check("stats_idle_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
